// File: rtl/ascii2morse_pkg.sv
// Shared definitions for the ASCII-to-Morse datapath: buffer geometry defaults,
// ASCII case-mapping constants and the read-side FSM state encoding.
package ascii2morse_pkg;

  localparam int BUF_ADDR_W = 10;
  localparam int BUF_DATA_W = 8;

  localparam logic [7:0] ASCII_LOWER_A     = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z     = 8'h7A;
  localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    LOAD  = 2'd2,
    VALID = 2'd3
  } reader_state_t;

endpackage

// File: rtl/buffer_reader_if.sv
// Byte stream from the buffer reader to the Morse encoder (valid/ready).
// The reader drives data/valid through the master modport; the encoder owns ready.
interface buffer_reader_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;

  modport master (
    output o_data,
    output o_valid,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    output i_ready
  );
endinterface

// File: rtl/ascii_upcase.sv
// Combinational ASCII lower-to-upper case mapper; passes every other code through.
// ENABLE=0 turns it into a plain wire so callers can keep one datapath shape.
module ascii_upcase
  import ascii2morse_pkg::*;
#(
  parameter int DATA_W = BUF_DATA_W,
  parameter bit ENABLE = 1'b1
) (
  input  logic [DATA_W-1:0] byte_i,
  output logic [DATA_W-1:0] byte_o
);

  logic is_lower;

  assign is_lower = ENABLE
                 && (byte_i >= DATA_W'(ASCII_LOWER_A))
                 && (byte_i <= DATA_W'(ASCII_LOWER_Z));

  assign byte_o = is_lower ? (byte_i - DATA_W'(ASCII_CASE_OFFSET)) : byte_i;

endmodule

// File: rtl/buffer_reader.sv
// Read side of the ASCII receive buffer: chases the write pointer, fetches bytes through
// the buffer's registered read port and hands them to the Morse encoder over valid/ready.
module buffer_reader
  import ascii2morse_pkg::*;
#(
  parameter int ADDR_W = BUF_ADDR_W,
  parameter int DATA_W = BUF_DATA_W,
  parameter bit UPCASE = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [ADDR_W-1:0]   i_w_address,
  input  logic [DATA_W-1:0]   i_data,
  output logic [ADDR_W-1:0]   r_address,
  input  logic                i_flush,
  buffer_reader_if.master     enc,
  output logic [ADDR_W-1:0]   o_count,
  output logic                o_empty
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_READ  = READ;
  localparam logic [1:0] ST_LOAD  = LOAD;
  localparam logic [1:0] ST_VALID = VALID;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] r_address_q, r_address_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] count;
  logic [DATA_W-1:0] data_mapped;

  // Modular distance; a completely full buffer reads as empty by design.
  assign count     = i_w_address - r_address_q;
  assign o_count   = count;
  assign o_empty   = (count == '0);
  assign r_address = r_address_q;

  assign enc.o_data  = data_q;
  assign enc.o_valid = valid_q;

  ascii_upcase #(
    .DATA_W (DATA_W),
    .ENABLE (UPCASE)
  ) u_upcase (
    .byte_i (i_data),
    .byte_o (data_mapped)
  );

  always_comb begin
    state_d     = state_q;
    r_address_d = r_address_q;
    data_d      = data_q;
    valid_d     = valid_q;

    if (i_flush) begin
      // Flush beats a same-cycle handshake: the presented byte is dropped, not consumed.
      r_address_d = i_w_address;
      valid_d     = 1'b0;
      state_d     = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (count != '0) begin
            state_d = ST_READ;
          end
        end
        ST_READ: begin
          state_d = ST_LOAD;
        end
        ST_LOAD: begin
          data_d      = data_mapped;
          valid_d     = 1'b1;
          r_address_d = r_address_q + ADDR_W'(1);
          state_d     = ST_VALID;
        end
        ST_VALID: begin
          // count is already post-increment here, since the pointer moved at LOAD.
          if (valid_q && enc.i_ready) begin
            valid_d = 1'b0;
            state_d = (count != '0) ? ST_READ : ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      r_address_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_address_q <= r_address_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

endmodule
